// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the 5-stage LoongArch32 pipeline.
//  - Owns the PC and drives the synchronous inst SRAM (data returns one cycle
//    after the address is presented with inst_sram_en high).
//  - Applies branch/jump redirects from ID. A redirect that arrives while IF
//    is stalled is remembered (br_pend) and used by the first fetch after the
//    stall. The newest redirect always wins.
//  - Hands {pc, inst} to ID under a valid/allowin handshake. The instruction
//    sitting in IF when a redirect is seen is wrong-path and is never offered.
// Configuration macro:
//  IF_INST_BUF_EN : adds a 32-bit instruction buffer that captures the SRAM
//                   output on the first stalled cycle, so the stage does not
//                   depend on the SRAM holding its output while en=0.
//                   Undefined (default): inst comes straight from the SRAM.
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1bff_fffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  // Decoded redirect from ID (combinational, same cycle).
  logic        br_taken_s;
  logic [31:0] br_target_s;

  // Handshake and fetch control.
  logic        to_fs_valid_s;
  logic        fs_ready_go_s;
  logic        fs_allowin_s;
  logic        fetch_s;
  logic [31:0] seq_pc_s;
  logic [31:0] nextpc_s;
  logic [31:0] fs_inst_s;

  // Architectural state of the stage.
  logic        fs_valid_q;
  logic        fs_valid_d;
  logic [31:0] fs_pc_q;
  logic [31:0] fs_pc_d;
  logic        br_pend_q;
  logic        br_pend_d;
  logic [31:0] br_pend_target_q;
  logic [31:0] br_pend_target_d;

  assign br_taken_s    = br_bus[32];
  assign br_target_s   = br_bus[31:0];

  // Pre-IF always requests a fetch once reset is released.
  assign to_fs_valid_s = ~reset;
  assign fs_ready_go_s = 1'b1;
  assign fs_allowin_s  = ~fs_valid_q | (fs_ready_go_s & ds_allowin);
  assign fetch_s       = to_fs_valid_s & fs_allowin_s;
  assign seq_pc_s      = fs_pc_q + 32'd4;

  // Next fetch address: live redirect, then remembered redirect, then sequential.
  always_comb begin
    if (br_taken_s) begin
      nextpc_s = br_target_s;
    end else if (br_pend_q) begin
      nextpc_s = br_pend_target_q;
    end else begin
      nextpc_s = seq_pc_s;
    end
  end

  // Next-state for valid, PC and the pending-redirect record.
  always_comb begin
    fs_valid_d       = fs_valid_q;
    fs_pc_d          = fs_pc_q;
    br_pend_d        = br_pend_q;
    br_pend_target_d = br_pend_target_q;

    if (fs_allowin_s) begin
      fs_valid_d = to_fs_valid_s;
    end else begin
      fs_valid_d = fs_valid_q;
    end

    if (fetch_s) begin
      // A fetch consumes any remembered redirect (nextpc already used it).
      fs_pc_d   = nextpc_s;
      br_pend_d = 1'b0;
    end else if (br_taken_s && !fs_allowin_s) begin
      // Stalled: remember the redirect; a later one overwrites the target.
      br_pend_d        = 1'b1;
      br_pend_target_d = br_target_s;
    end else begin
      br_pend_d        = br_pend_q;
      br_pend_target_d = br_pend_target_q;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_PC;
      br_pend_q        <= 1'b0;
      br_pend_target_q <= 32'h0000_0000;
    end else begin
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      br_pend_q        <= br_pend_d;
      br_pend_target_q <= br_pend_target_d;
    end
  end

`ifdef IF_INST_BUF_EN
  logic        inst_buf_valid_q;
  logic        inst_buf_valid_d;
  logic [31:0] inst_buf_q;
  logic [31:0] inst_buf_d;

  // Capture SRAM data on the first stalled cycle; release on any allowin edge.
  always_comb begin
    inst_buf_valid_d = inst_buf_valid_q;
    inst_buf_d       = inst_buf_q;
    if (fs_allowin_s) begin
      inst_buf_valid_d = 1'b0;
    end else if (!inst_buf_valid_q) begin
      inst_buf_valid_d = 1'b1;
      inst_buf_d       = inst_sram_rdata;
    end else begin
      inst_buf_valid_d = inst_buf_valid_q;
      inst_buf_d       = inst_buf_q;
    end
  end

  // Instruction buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_buf_valid_q <= 1'b0;
      inst_buf_q       <= 32'h0000_0000;
    end else begin
      inst_buf_valid_q <= inst_buf_valid_d;
      inst_buf_q       <= inst_buf_d;
    end
  end

  assign fs_inst_s = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;
`else
  // SRAM is expected to hold its last output while inst_sram_en is low.
  assign fs_inst_s = inst_sram_rdata;
`endif

  // Wrong-path instruction is squashed while any redirect is live or pending.
  assign fs_to_ds_valid  = fs_valid_q & fs_ready_go_s & ~br_taken_s & ~br_pend_q;
  assign fs_to_ds_bus    = {fs_pc_q, fs_inst_s};

  assign inst_sram_en    = fetch_s;
  assign inst_sram_we    = 1'b0;
  assign inst_sram_addr  = nextpc_s;
  assign inst_sram_wdata = 32'h0000_0000;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage : self-checking bench for if_stage.
// A behavioural synchronous SRAM returns inst_of(addr) one cycle after an
// enabled request. With IF_INST_BUF_EN it scrambles its output while en=0.
// Each scenario pushes the PCs that ID must accept onto a queue; a monitor
// pops and compares every accepted {pc, inst}.
// ---------------------------------------------------------------------------
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ds_allowin = 1'b1;
  logic [32:0] br_bus = 33'h0;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] sram_rdata = 32'h0;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a ^ 32'h5a5a_c3c3) + {a[7:0], a[15:8], 16'h1234};
  endfunction

  always #5 clk = ~clk;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allowin      (ds_allowin),
    .br_bus          (br_bus),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (sram_rdata)
  );

  // Synchronous instruction SRAM model.
  always @(posedge clk) begin
    if (inst_sram_en) sram_rdata <= inst_of(inst_sram_addr);
`ifdef IF_INST_BUF_EN
    else sram_rdata <= $urandom;
`endif
  end

  // Scoreboard monitor: every instruction accepted by ID must be the next expected one.
  always @(negedge clk) begin
    if (!reset && fs_to_ds_valid === 1'b1 && ds_allowin === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL deliver_unexpected: got bus=%h, none expected", fs_to_ds_bus);
      end else begin
        mon_exp = exp_q.pop_front();
        if (fs_to_ds_bus !== {mon_exp, inst_of(mon_exp)}) begin
          errors++;
          $display("FAIL deliver: got %h expected %h", fs_to_ds_bus, {mon_exp, inst_of(mon_exp)});
        end
      end
    end
  end

  // Hard stop so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got valid=%b en=%b expected 0 0", fs_to_ds_valid, inst_sram_en);
      end
      checks++;
      if (inst_sram_we !== 1'b0 || inst_sram_wdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_we_wdata: got we=%b wdata=%h expected 0 0", inst_sram_we, inst_sram_wdata);
      end
      if (i < 2) tick();
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    exp_q.push_back(32'h1c00_0000);
    exp_q.push_back(32'h1c00_0004);
    @(negedge clk);
    checks++;
    if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_0000) begin
      errors++;
      $display("FAIL first_fetch: got valid=%b en=%b addr=%h expected 0 1 1c000000",
               fs_to_ds_valid, inst_sram_en, inst_sram_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus[63:32] !== 32'h1c00_0000 || inst_sram_addr !== 32'h1c00_0004) begin
      errors++;
      $display("FAIL first_valid: got valid=%b pc=%h addr=%h expected 1 1c000000 1c000004",
               fs_to_ds_valid, fs_to_ds_bus[63:32], inst_sram_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (inst_sram_addr !== 32'h1c00_0008) begin
      errors++;
      $display("FAIL seq_addr: got %h expected 1c000008", inst_sram_addr);
    end
    tick();
  endtask

  task automatic test_stall();
    ds_allowin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (inst_sram_en !== 1'b0 || fs_to_ds_bus !== {32'h1c00_0008, inst_of(32'h1c00_0008)}) begin
        errors++;
        $display("FAIL stall_hold: got en=%b bus=%h expected 0 %h",
                 inst_sram_en, fs_to_ds_bus, {32'h1c00_0008, inst_of(32'h1c00_0008)});
      end
      tick();
    end
    ds_allowin = 1'b1;
    exp_q.push_back(32'h1c00_0008);
    exp_q.push_back(32'h1c00_000c);
    @(negedge clk);
    checks++;
    if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_000c) begin
      errors++;
      $display("FAIL stall_release: got en=%b addr=%h expected 1 1c00000c", inst_sram_en, inst_sram_addr);
    end
    tick();
    @(negedge clk);
    tick();
  endtask

  task automatic test_branch();
    br_bus = {1'b1, 32'h1c00_0100};
    @(negedge clk);
    checks++;
    if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_0100) begin
      errors++;
      $display("FAIL branch_cancel: got valid=%b en=%b addr=%h expected 0 1 1c000100",
               fs_to_ds_valid, inst_sram_en, inst_sram_addr);
    end
    exp_q.push_back(32'h1c00_0100);
    tick();
    br_bus = 33'h0;
    @(negedge clk);
    checks++;
    if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus[63:32] !== 32'h1c00_0100 || inst_sram_addr !== 32'h1c00_0104) begin
      errors++;
      $display("FAIL branch_target: got valid=%b pc=%h addr=%h expected 1 1c000100 1c000104",
               fs_to_ds_valid, fs_to_ds_bus[63:32], inst_sram_addr);
    end
    tick();
  endtask

  task automatic test_branch_stalled();
    ds_allowin = 1'b0;
    br_bus = {1'b1, 32'h1c00_0200};
    @(negedge clk);
    checks++;
    if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b0) begin
      errors++;
      $display("FAIL brst_cancel: got valid=%b en=%b expected 0 0", fs_to_ds_valid, inst_sram_en);
    end
    tick();
    br_bus = 33'h0;
    @(negedge clk);
    checks++;
    if (dut.br_pend_q !== 1'b1 || fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b0) begin
      errors++;
      $display("FAIL brst_pend: got pend=%b valid=%b en=%b expected 1 0 0",
               dut.br_pend_q, fs_to_ds_valid, inst_sram_en);
    end
    tick();
    ds_allowin = 1'b1;
    exp_q.push_back(32'h1c00_0200);
    @(negedge clk);
    checks++;
    if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_0200) begin
      errors++;
      $display("FAIL brst_release: got valid=%b en=%b addr=%h expected 0 1 1c000200",
               fs_to_ds_valid, inst_sram_en, inst_sram_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus[63:32] !== 32'h1c00_0200) begin
      errors++;
      $display("FAIL brst_target: got valid=%b pc=%h expected 1 1c000200", fs_to_ds_valid, fs_to_ds_bus[63:32]);
    end
    tick();
  endtask

  task automatic test_double_redirect();
    ds_allowin = 1'b0;
    br_bus = {1'b1, 32'h1c00_0300};
    @(negedge clk);
    tick();
    br_bus = {1'b1, 32'h1c00_0400};
    @(negedge clk);
    checks++;
    if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b0) begin
      errors++;
      $display("FAIL dbl_stall: got valid=%b en=%b expected 0 0", fs_to_ds_valid, inst_sram_en);
    end
    tick();
    br_bus = 33'h0;
    @(negedge clk);
    tick();
    ds_allowin = 1'b1;
    exp_q.push_back(32'h1c00_0400);
    @(negedge clk);
    checks++;
    if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_0400) begin
      errors++;
      $display("FAIL dbl_newest: got en=%b addr=%h expected 1 1c000400", inst_sram_en, inst_sram_addr);
    end
    tick();
    @(negedge clk);
    tick();
  endtask

  task automatic test_wrap_misaligned();
    br_bus = {1'b1, 32'hffff_fffc};
    exp_q.push_back(32'hffff_fffc);
    exp_q.push_back(32'h0000_0000);
    @(negedge clk);
    checks++;
    if (inst_sram_addr !== 32'hffff_fffc) begin
      errors++;
      $display("FAIL wrap_target: got %h expected fffffffc", inst_sram_addr);
    end
    tick();
    br_bus = 33'h0;
    @(negedge clk);
    checks++;
    if (inst_sram_addr !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_next: got %h expected 00000000", inst_sram_addr);
    end
    tick();
    @(negedge clk);
    tick();
    br_bus = {1'b1, 32'h1c00_0502};
    exp_q.push_back(32'h1c00_0502);
    @(negedge clk);
    tick();
    br_bus = 33'h0;
    @(negedge clk);
    checks++;
    if (inst_sram_addr !== 32'h1c00_0506) begin
      errors++;
      $display("FAIL misaligned_next: got %h expected 1c000506", inst_sram_addr);
    end
    tick();
  endtask

  task automatic test_back_to_back(input logic [31:0] start_pc);
    int cyc;
    bit done;
    cyc  = 0;
    done = 1'b0;
    for (int i = 0; i < 16; i++) exp_q.push_back(start_pc + 32'(4 * i));
    while (!done && cyc < 300) begin
      tick();
      ds_allowin = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      #1;
      cyc++;
      if (exp_q.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d left expected 0", exp_q.size());
    end
    tick();
    ds_allowin = 1'b0;
  endtask

  task automatic test_inst_buf(input logic [31:0] pc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (inst_sram_en !== 1'b0 || fs_to_ds_bus !== {pc, inst_of(pc)}) begin
        errors++;
        $display("FAIL inst_buf_hold: got en=%b bus=%h expected 0 %h", inst_sram_en, fs_to_ds_bus, {pc, inst_of(pc)});
      end
      tick();
    end
    ds_allowin = 1'b1;
    exp_q.push_back(pc);
    @(negedge clk);
    tick();
    ds_allowin = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_stalled();
    test_double_redirect();
    test_wrap_misaligned();
    test_back_to_back(32'h1c00_0506);
    test_inst_buf(32'h1c00_0546);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
